// File: rtl/commit_unit_nw.sv
// N-wide in-order retire stage: pops the longest legal prefix of the ROB head window and emits
// registered rename-commit, flush/redirect, exception and branch-predictor update records.
module commit_unit_nw #(
    parameter int unsigned W          = 2,
    parameter int unsigned PRF_W      = 6,
    parameter logic [31:0] EXC_VECTOR = 32'hBFC0_0380,
    parameter logic [4:0]  ERET_CODE  = 5'h1F,
    localparam int unsigned CNT_W     = $clog2(W + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [W-1:0]       i_slot_valid,
    input  logic [W-1:0]       i_slot_done,
    input  logic [W-1:0]       i_slot_exc,
    input  logic [W-1:0]       i_slot_is_ds,
    input  logic [W-1:0]       i_slot_is_br,
    input  logic [W-1:0]       i_slot_br_taken,
    input  logic [W-1:0]       i_slot_pred_taken,
    input  logic [W-1:0]       i_slot_is_store,
    input  logic [W-1:0]       i_slot_dst_we,
    input  logic [5*W-1:0]     i_slot_exc_code,
    input  logic [32*W-1:0]    i_slot_pc,
    input  logic [32*W-1:0]    i_slot_br_target,
    input  logic [32*W-1:0]    i_slot_pred_target,
    input  logic [32*W-1:0]    i_slot_badvaddr,
    input  logic [5*W-1:0]     i_slot_dst_larf,
    input  logic [PRF_W*W-1:0] i_slot_dst_pprf,
    input  logic [PRF_W*W-1:0] i_slot_dst_stale,
    input  logic [5:0]         i_ext_int,
    input  logic               i_counter_int,
    input  logic               i_status_ie,
    input  logic               i_status_exl,
    input  logic [7:0]         i_status_im,
    input  logic [1:0]         i_cause_ip_sw,
    input  logic [31:0]        i_epc,
    output logic [CNT_W-1:0]   o_rob_retire_cnt,
    output logic [CNT_W-1:0]   o_store_fire_cnt,
    output logic [W-1:0]       o_rn_valid,
    output logic [W-1:0]       o_rn_we,
    output logic [5*W-1:0]     o_rn_larf,
    output logic [PRF_W*W-1:0] o_rn_pprf,
    output logic [PRF_W*W-1:0] o_rn_stale,
    output logic               o_flush_req,
    output logic               o_redirect_valid,
    output logic [31:0]        o_redirect_pc,
    output logic               o_exc_valid,
    output logic               o_exc_is_ds,
    output logic [4:0]         o_exc_code,
    output logic [31:0]        o_exc_pc,
    output logic [31:0]        o_exc_badvaddr,
    output logic               o_bpd_valid,
    output logic               o_bpd_taken,
    output logic [31:0]        o_bpd_pc,
    output logic [31:0]        o_bpd_target
);

    typedef enum logic [1:0] {StRun, StWaitDs, StFlush} state_e;

    state_e               r_state;
    logic [5:0]           r_int_sync;
    logic [31:0]          r_hold_tgt;
    logic [W-1:0]         r_rn_valid;
    logic [W-1:0]         r_rn_we;
    logic [5*W-1:0]       r_rn_larf;
    logic [PRF_W*W-1:0]   r_rn_pprf;
    logic [PRF_W*W-1:0]   r_rn_stale;
    logic                 r_flush;
    logic [31:0]          r_redir_pc;
    logic                 r_exc_valid;
    logic                 r_exc_is_ds;
    logic [4:0]           r_exc_code;
    logic [31:0]          r_exc_pc;
    logic [31:0]          r_exc_bad;
    logic                 r_bpd_valid;
    logic                 r_bpd_taken;
    logic [31:0]          r_bpd_pc;
    logic [31:0]          r_bpd_tgt;

    logic [W-1:0]         w_ok;
    logic [W-1:0]         w_mispred;
    logic [31:0]          w_tgt [W];
    logic [7:0]           w_int_pend;
    logic                 w_int_take;
    logic                 w_unused_ext5;

    state_e               w_state_d;
    logic [W-1:0]         w_retired;
    logic                 w_exc;
    logic                 w_exc_int;
    int unsigned          w_exc_idx;
    logic [4:0]           w_exc_code;
    logic [31:0]          w_exc_pc;
    logic [31:0]          w_exc_bad;
    logic                 w_exc_ds;
    logic                 w_br_redir;
    logic [31:0]          w_br_tgt;
    logic [31:0]          w_hold_d;
    logic [31:0]          w_pend_tgt;
    logic                 w_ds_pend;
    logic                 w_stop;
    logic                 w_flush;
    logic [31:0]          w_redir_pc;
    logic [CNT_W-1:0]     w_retire_cnt;
    logic [CNT_W-1:0]     w_store_cnt;
    logic                 w_bpd_valid;
    logic                 w_bpd_taken;
    logic [31:0]          w_bpd_pc;
    logic [31:0]          w_bpd_tgt;

    // ext_int[5] is shared with the timer and is replaced by counter_int.
    assign w_unused_ext5 = i_ext_int[5];
    assign w_int_pend    = {r_int_sync, i_cause_ip_sw};
    assign w_int_take    = (|(w_int_pend & i_status_im)) & i_status_ie & ~i_status_exl;

    always_comb begin
        for (int unsigned i = 0; i < W; i++) begin
            w_ok[i]      = i_slot_valid[i] & i_slot_done[i];
            w_tgt[i]     = i_slot_br_taken[i] ? i_slot_br_target[i*32 +: 32]
                                              : i_slot_pc[i*32 +: 32] + 32'd8;
            w_mispred[i] = i_slot_is_br[i] &
                           ((i_slot_br_taken[i] != i_slot_pred_taken[i]) |
                            (i_slot_br_taken[i] &
                             (i_slot_br_target[i*32 +: 32] != i_slot_pred_target[i*32 +: 32])));
        end
    end

    always_comb begin
        w_state_d  = r_state;
        w_retired  = '0;
        w_exc      = 1'b0;
        w_exc_int  = 1'b0;
        w_exc_idx  = 0;
        w_br_redir = 1'b0;
        w_br_tgt   = r_hold_tgt;
        w_hold_d   = r_hold_tgt;
        w_pend_tgt = '0;
        w_ds_pend  = 1'b0;
        w_stop     = 1'b0;
        case (r_state)
            StRun: begin
                if (w_int_take && i_slot_valid[0]) begin
                    w_exc     = 1'b1;
                    w_exc_int = 1'b1;
                    w_state_d = StFlush;
                end else begin
                    for (int unsigned i = 0; i < W; i++) begin
                        if (!w_stop) begin
                            if (w_ds_pend) begin
                                // Slot i is the delay slot of a mispredicted branch.
                                w_stop = 1'b1;
                                if (w_ok[i] && i_slot_exc[i]) begin
                                    w_exc     = 1'b1;
                                    w_exc_idx = i;
                                    w_state_d = StFlush;
                                end else if (w_ok[i]) begin
                                    w_retired[i] = 1'b1;
                                    w_br_redir   = 1'b1;
                                    w_br_tgt     = w_pend_tgt;
                                    w_state_d    = StFlush;
                                end else begin
                                    w_hold_d  = w_pend_tgt;
                                    w_state_d = StWaitDs;
                                end
                            end else if (!w_ok[i]) begin
                                w_stop = 1'b1;
                            end else if (i_slot_exc[i]) begin
                                w_stop    = 1'b1;
                                w_exc     = 1'b1;
                                w_exc_idx = i;
                                w_state_d = StFlush;
                            end else begin
                                w_retired[i] = 1'b1;
                                if (w_mispred[i]) begin
                                    w_ds_pend  = 1'b1;
                                    w_pend_tgt = w_tgt[i];
                                end
                            end
                        end
                    end
                    if (w_ds_pend && !w_stop) begin
                        w_hold_d  = w_pend_tgt;
                        w_state_d = StWaitDs;
                    end
                end
            end
            StWaitDs: begin
                if (w_int_take && i_slot_valid[0]) begin
                    w_exc     = 1'b1;
                    w_exc_int = 1'b1;
                    w_state_d = StFlush;
                end else if (w_ok[0] && i_slot_exc[0]) begin
                    w_exc     = 1'b1;
                    w_state_d = StFlush;
                end else if (w_ok[0]) begin
                    w_retired[0] = 1'b1;
                    w_br_redir   = 1'b1;
                    w_state_d    = StFlush;
                end
            end
            StFlush: w_state_d = StRun;
            default: w_state_d = StRun;
        endcase
    end

    always_comb begin
        w_exc_code = '0;
        w_exc_pc   = '0;
        w_exc_bad  = '0;
        w_exc_ds   = 1'b0;
        w_redir_pc = '0;
        if (w_exc) begin
            w_exc_code = w_exc_int ? 5'd0 : i_slot_exc_code[w_exc_idx*5 +: 5];
            w_exc_pc   = i_slot_pc[w_exc_idx*32 +: 32];
            w_exc_bad  = w_exc_int ? 32'd0 : i_slot_badvaddr[w_exc_idx*32 +: 32];
            w_exc_ds   = i_slot_is_ds[w_exc_idx];
            w_redir_pc = (w_exc_code == ERET_CODE) ? i_epc : EXC_VECTOR;
        end else if (w_br_redir) begin
            w_redir_pc = w_br_tgt;
        end
    end

    assign w_flush = w_exc | w_br_redir;

    always_comb begin
        w_retire_cnt = '0;
        w_store_cnt  = '0;
        w_bpd_valid  = 1'b0;
        w_bpd_taken  = 1'b0;
        w_bpd_pc     = '0;
        w_bpd_tgt    = '0;
        for (int unsigned i = 0; i < W; i++) begin
            w_retire_cnt = w_retire_cnt + CNT_W'(w_retired[i]);
            w_store_cnt  = w_store_cnt + CNT_W'(w_retired[i] & i_slot_is_store[i]);
            if (!w_bpd_valid && w_retired[i] && i_slot_is_br[i]) begin
                w_bpd_valid = 1'b1;
                w_bpd_taken = i_slot_br_taken[i];
                w_bpd_pc    = i_slot_pc[i*32 +: 32];
                w_bpd_tgt   = i_slot_br_target[i*32 +: 32];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= StRun;
            r_int_sync  <= '0;
            r_hold_tgt  <= '0;
            r_rn_valid  <= '0;
            r_rn_we     <= '0;
            r_rn_larf   <= '0;
            r_rn_pprf   <= '0;
            r_rn_stale  <= '0;
            r_flush     <= 1'b0;
            r_redir_pc  <= '0;
            r_exc_valid <= 1'b0;
            r_exc_is_ds <= 1'b0;
            r_exc_code  <= '0;
            r_exc_pc    <= '0;
            r_exc_bad   <= '0;
            r_bpd_valid <= 1'b0;
            r_bpd_taken <= 1'b0;
            r_bpd_pc    <= '0;
            r_bpd_tgt   <= '0;
        end else begin
            r_state     <= w_state_d;
            r_int_sync  <= {i_counter_int, i_ext_int[4:0]};
            r_hold_tgt  <= w_hold_d;
            r_rn_valid  <= w_retired;
            r_rn_we     <= w_retired & i_slot_dst_we;
            r_rn_larf   <= i_slot_dst_larf;
            r_rn_pprf   <= i_slot_dst_pprf;
            r_rn_stale  <= i_slot_dst_stale;
            r_flush     <= w_flush;
            r_redir_pc  <= w_redir_pc;
            r_exc_valid <= w_exc;
            r_exc_is_ds <= w_exc_ds;
            r_exc_code  <= w_exc_code;
            r_exc_pc    <= w_exc_pc;
            r_exc_bad   <= w_exc_bad;
            r_bpd_valid <= w_bpd_valid;
            r_bpd_taken <= w_bpd_taken;
            r_bpd_pc    <= w_bpd_pc;
            r_bpd_tgt   <= w_bpd_tgt;
        end
    end

    assign o_rob_retire_cnt = w_retire_cnt;
    assign o_store_fire_cnt = w_store_cnt;
    assign o_rn_valid       = r_rn_valid;
    assign o_rn_we          = r_rn_we;
    assign o_rn_larf        = r_rn_larf;
    assign o_rn_pprf        = r_rn_pprf;
    assign o_rn_stale       = r_rn_stale;
    assign o_flush_req      = r_flush;
    assign o_redirect_valid = r_flush;
    assign o_redirect_pc    = r_redir_pc;
    assign o_exc_valid      = r_exc_valid;
    assign o_exc_is_ds      = r_exc_is_ds;
    assign o_exc_code       = r_exc_code;
    assign o_exc_pc         = r_exc_pc;
    assign o_exc_badvaddr   = r_exc_bad;
    assign o_bpd_valid      = r_bpd_valid;
    assign o_bpd_taken      = r_bpd_taken;
    assign o_bpd_pc         = r_bpd_pc;
    assign o_bpd_target     = r_bpd_tgt;

endmodule

// File: tb/tb_commit_unit_nw.sv
// Bench for commit_unit_nw: directed scenarios plus a randomized run against a retire model.
module tb_commit_unit_nw;
    localparam int W     = 2;
    localparam int PRF_W = 6;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [W-1:0]       valid, done, exc, is_ds, is_br, br_taken, pred_taken, is_store, dst_we;
    logic [5*W-1:0]     exc_code, larf;
    logic [32*W-1:0]    pc, br_target, pred_target, badvaddr;
    logic [PRF_W*W-1:0] pprf, stale;
    logic [5:0]         ext_int;
    logic               counter_int, ie, exl;
    logic [7:0]         im;
    logic [1:0]         ip_sw;
    logic [31:0]        epc;

    logic [1:0]         o_cnt, o_st;
    logic [W-1:0]       o_rn_valid, o_rn_we;
    logic [5*W-1:0]     o_rn_larf;
    logic [PRF_W*W-1:0] o_rn_pprf, o_rn_stale;
    logic               o_flush, o_rvalid, o_exc_valid, o_exc_is_ds, o_bpd_valid, o_bpd_taken;
    logic [31:0]        o_rpc, o_exc_pc, o_exc_bad, o_bpd_pc, o_bpd_tgt;
    logic [4:0]         o_exc_code;

    commit_unit_nw #(.W(W), .PRF_W(PRF_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_slot_valid(valid), .i_slot_done(done), .i_slot_exc(exc), .i_slot_is_ds(is_ds),
        .i_slot_is_br(is_br), .i_slot_br_taken(br_taken), .i_slot_pred_taken(pred_taken),
        .i_slot_is_store(is_store), .i_slot_dst_we(dst_we), .i_slot_exc_code(exc_code),
        .i_slot_pc(pc), .i_slot_br_target(br_target), .i_slot_pred_target(pred_target),
        .i_slot_badvaddr(badvaddr), .i_slot_dst_larf(larf), .i_slot_dst_pprf(pprf),
        .i_slot_dst_stale(stale), .i_ext_int(ext_int), .i_counter_int(counter_int),
        .i_status_ie(ie), .i_status_exl(exl), .i_status_im(im), .i_cause_ip_sw(ip_sw),
        .i_epc(epc),
        .o_rob_retire_cnt(o_cnt), .o_store_fire_cnt(o_st), .o_rn_valid(o_rn_valid),
        .o_rn_we(o_rn_we), .o_rn_larf(o_rn_larf), .o_rn_pprf(o_rn_pprf),
        .o_rn_stale(o_rn_stale), .o_flush_req(o_flush), .o_redirect_valid(o_rvalid),
        .o_redirect_pc(o_rpc), .o_exc_valid(o_exc_valid), .o_exc_is_ds(o_exc_is_ds),
        .o_exc_code(o_exc_code), .o_exc_pc(o_exc_pc), .o_exc_badvaddr(o_exc_bad),
        .o_bpd_valid(o_bpd_valid), .o_bpd_taken(o_bpd_taken), .o_bpd_pc(o_bpd_pc),
        .o_bpd_target(o_bpd_tgt)
    );

    int checks = 0;
    int errors = 0;

    // Reference model state: waiting on a delay slot, in the flush bubble, held target, int sync.
    bit          m_wait, m_flush, m_wait_n, m_flush_n;
    logic [31:0] m_hold, m_hold_n;
    logic [5:0]  m_sync, m_sync_n;
    int          e_cnt, e_st;
    logic [W-1:0] e_mask, e_we;
    bit          e_flush, e_exc_valid, e_exc_ds, e_bpd_valid, e_bpd_taken;
    logic [4:0]  e_code;
    logic [31:0] e_rpc, e_exc_pc, e_exc_bad, e_bpd_pc, e_bpd_tgt;
    logic [5*W-1:0]     e_larf;
    logic [PRF_W*W-1:0] e_pprf, e_stale;

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_slots();
        valid = '0; done = '0; exc = '0; is_ds = '0; is_br = '0; br_taken = '0;
        pred_taken = '0; is_store = '0; dst_we = '0; exc_code = '0; larf = '0;
        pc = '0; br_target = '0; pred_target = '0; badvaddr = '0; pprf = '0; stale = '0;
    endtask

    task automatic set_alu(input int i, input logic [31:0] p);
        valid[i] = 1'b1; done[i] = 1'b1; dst_we[i] = 1'b1; pc[i*32 +: 32] = p;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        clr_slots();
        ext_int = '0; counter_int = 1'b0; ie = 1'b0; exl = 1'b0; im = '0; ip_sw = '0;
        epc = '0;
        m_wait = 0; m_flush = 0; m_hold = '0; m_sync = '0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    function automatic bit mispred(int k);
        return is_br[k] && ((br_taken[k] != pred_taken[k]) ||
            (br_taken[k] && br_target[k*32 +: 32] != pred_target[k*32 +: 32]));
    endfunction

    // Retire-group model: count how many head slots leave, then derive every record from that.
    task automatic model_eval();
        bit take, redir, is_int;
        int n, exk;
        logic [31:0] tgt;
        take = (|({m_sync, ip_sw} & im)) && ie && !exl;
        m_sync_n = {counter_int, ext_int[4:0]};
        m_wait_n = 0; m_flush_n = 0; m_hold_n = m_hold;
        n = 0; exk = -1; redir = 0; tgt = '0; is_int = 0;
        if (m_flush) begin
            n = 0;
        end else if (take && valid[0]) begin
            exk = 0; is_int = 1;
        end else if (m_wait) begin
            if (!(valid[0] && done[0])) m_wait_n = 1;
            else if (exc[0]) exk = 0;
            else begin n = 1; redir = 1; tgt = m_hold; end
        end else begin
            for (int k = 0; k < W; k++) begin
                if (!(valid[k] && done[k])) break;
                if (exc[k]) begin exk = k; break; end
                n++;
                if (mispred(k)) begin
                    tgt = br_taken[k] ? br_target[k*32 +: 32] : pc[k*32 +: 32] + 32'd8;
                    if (k + 1 >= W) begin m_wait_n = 1; m_hold_n = tgt; end
                    else if (!(valid[k+1] && done[k+1])) begin m_wait_n = 1; m_hold_n = tgt; end
                    else if (exc[k+1]) exk = k + 1;
                    else begin n++; redir = 1; end
                    break;
                end
            end
        end
        e_mask = '0; e_st = 0; e_bpd_valid = 0; e_bpd_taken = 0; e_bpd_pc = '0; e_bpd_tgt = '0;
        for (int i = 0; i < n; i++) begin
            e_mask[i] = 1'b1;
            if (is_store[i]) e_st++;
            if (is_br[i] && !e_bpd_valid) begin
                e_bpd_valid = 1; e_bpd_taken = br_taken[i];
                e_bpd_pc = pc[i*32 +: 32]; e_bpd_tgt = br_target[i*32 +: 32];
            end
        end
        e_cnt = n; e_we = dst_we; e_larf = larf; e_pprf = pprf; e_stale = stale;
        e_exc_valid = (exk >= 0);
        e_code = '0; e_exc_pc = '0; e_exc_bad = '0; e_exc_ds = 0; e_rpc = '0;
        if (e_exc_valid) begin
            e_code    = is_int ? 5'd0 : exc_code[exk*5 +: 5];
            e_exc_pc  = pc[exk*32 +: 32];
            e_exc_bad = is_int ? 32'd0 : badvaddr[exk*32 +: 32];
            e_exc_ds  = is_ds[exk];
            e_rpc     = (e_code == 5'h1F) ? epc : 32'hBFC0_0380;
        end else if (redir) begin
            e_rpc = tgt;
        end
        e_flush = e_exc_valid || redir;
        if (e_flush) m_flush_n = 1;
    endtask

    task automatic test_reset();
        do_reset();
        checks++; if (o_cnt !== 2'd0) begin errors++; $display("FAIL rst_cnt got %0d want 0", o_cnt); end
        checks++; if (o_rn_valid !== 2'b00) begin errors++; $display("FAIL rst_rn_valid got %b want 00", o_rn_valid); end
        checks++; if ({o_flush, o_rvalid, o_exc_valid, o_bpd_valid} !== 4'b0) begin
            errors++; $display("FAIL rst_flags got %b want 0000", {o_flush, o_rvalid, o_exc_valid, o_bpd_valid}); end
        checks++; if (o_rpc !== 32'd0) begin errors++; $display("FAIL rst_rpc got %h want 0", o_rpc); end
    endtask

    task automatic test_alu_pair();
        set_alu(0, 32'h100); set_alu(1, 32'h104);
        #1;
        checks++; if (o_cnt !== 2'd2) begin errors++; $display("FAIL alu_cnt got %0d want 2", o_cnt); end
        cycle(); clr_slots();
        checks++; if (o_rn_valid !== 2'b11) begin errors++; $display("FAIL alu_rn_valid got %b want 11", o_rn_valid); end
        checks++; if (o_rn_we !== 2'b11) begin errors++; $display("FAIL alu_rn_we got %b want 11", o_rn_we); end
        checks++; if (o_flush !== 1'b0) begin errors++; $display("FAIL alu_flush got %b want 0", o_flush); end
        cycle();
    endtask

    task automatic test_mispredict();
        set_alu(0, 32'h1000); is_br[0] = 1'b1; br_taken[0] = 1'b1; br_target[31:0] = 32'h2000;
        set_alu(1, 32'h1004);
        #1;
        checks++; if (o_cnt !== 2'd2) begin errors++; $display("FAIL mp_cnt got %0d want 2", o_cnt); end
        cycle(); clr_slots();
        checks++; if (o_rvalid !== 1'b1 || o_flush !== 1'b1) begin
            errors++; $display("FAIL mp_redirect got %b%b want 11", o_rvalid, o_flush); end
        checks++; if (o_rpc !== 32'h2000) begin errors++; $display("FAIL mp_rpc got %h want 2000", o_rpc); end
        checks++; if (o_bpd_valid !== 1'b1 || o_bpd_pc !== 32'h1000 || o_bpd_tgt !== 32'h2000) begin
            errors++; $display("FAIL mp_bpd got %b %h %h want 1 1000 2000", o_bpd_valid, o_bpd_pc, o_bpd_tgt); end
        cycle();
        checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL mp_one_cycle got %b want 0", o_rvalid); end
    endtask

    task automatic test_wait_ds();
        set_alu(0, 32'h200); set_alu(1, 32'h204); is_br[1] = 1'b1; pred_taken[1] = 1'b1;
        #1;
        checks++; if (o_cnt !== 2'd2) begin errors++; $display("FAIL wds_cnt got %0d want 2", o_cnt); end
        cycle(); clr_slots();
        for (int c = 0; c < 2; c++) begin
            valid = 2'b11; done = 2'b10; pc = {32'h20C, 32'h208};
            #1;
            checks++; if (o_cnt !== 2'd0) begin errors++; $display("FAIL wds_wait%0d got %0d want 0", c, o_cnt); end
            checks++; if (o_rvalid !== 1'b0) begin errors++; $display("FAIL wds_early got %b want 0", o_rvalid); end
            cycle();
        end
        clr_slots(); set_alu(0, 32'h208); set_alu(1, 32'h20C);
        #1;
        checks++; if (o_cnt !== 2'd1) begin errors++; $display("FAIL wds_ds_cnt got %0d want 1", o_cnt); end
        cycle(); clr_slots();
        checks++; if (o_rvalid !== 1'b1 || o_rpc !== 32'h20C) begin
            errors++; $display("FAIL wds_rpc got %b %h want 1 20c", o_rvalid, o_rpc); end
        cycle();
    endtask

    task automatic test_exception();
        set_alu(0, 32'h300); exc[0] = 1'b1; exc_code[4:0] = 5'd4; badvaddr[31:0] = 32'h3;
        set_alu(1, 32'h304);
        #1;
        checks++; if (o_cnt !== 2'd0) begin errors++; $display("FAIL exc_cnt got %0d want 0", o_cnt); end
        cycle(); clr_slots();
        checks++; if (o_exc_valid !== 1'b1 || o_exc_code !== 5'd4 || o_exc_pc !== 32'h300) begin
            errors++; $display("FAIL exc_rec got %b %0d %h want 1 4 300", o_exc_valid, o_exc_code, o_exc_pc); end
        checks++; if (o_exc_bad !== 32'h3) begin errors++; $display("FAIL exc_bad got %h want 3", o_exc_bad); end
        checks++; if (o_rpc !== 32'hBFC0_0380 || o_rn_valid !== 2'b00) begin
            errors++; $display("FAIL exc_rpc got %h %b want bfc00380 00", o_rpc, o_rn_valid); end
        cycle();
    endtask

    task automatic test_interrupt_eret();
        ext_int = 6'b000100; im = 8'h10; ie = 1'b1; exl = 1'b0;
        valid[0] = 1'b1; pc[31:0] = 32'h400;
        cycle();
        #1;
        checks++; if (o_cnt !== 2'd0) begin errors++; $display("FAIL int_cnt got %0d want 0", o_cnt); end
        cycle();
        checks++; if (o_exc_valid !== 1'b1 || o_exc_code !== 5'd0 || o_exc_pc !== 32'h400) begin
            errors++; $display("FAIL int_rec got %b %0d %h want 1 0 400", o_exc_valid, o_exc_code, o_exc_pc); end
        ext_int = '0; ie = 1'b0; clr_slots();
        cycle();
        set_alu(0, 32'h500); exc[0] = 1'b1; exc_code[4:0] = 5'h1F; epc = 32'h8000_0100;
        #1;
        checks++; if (o_cnt !== 2'd0) begin errors++; $display("FAIL eret_cnt got %0d want 0", o_cnt); end
        cycle(); clr_slots();
        checks++; if (o_exc_code !== 5'h1F || o_rpc !== 32'h8000_0100) begin
            errors++; $display("FAIL eret_rpc got %h %h want 1f 80000100", o_exc_code, o_rpc); end
        cycle();
    endtask

    task automatic test_stores_exc();
        set_alu(0, 32'h600); set_alu(1, 32'h604); is_store = 2'b11; exc[1] = 1'b1;
        #1;
        checks++; if (o_st !== 2'd1) begin errors++; $display("FAIL st_cnt got %0d want 1", o_st); end
        checks++; if (o_cnt !== 2'd1) begin errors++; $display("FAIL st_retire got %0d want 1", o_cnt); end
        cycle(); clr_slots();
        checks++; if (o_exc_pc !== 32'h604) begin errors++; $display("FAIL st_exc_pc got %h want 604", o_exc_pc); end
        cycle();
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            for (int i = 0; i < W; i++) begin
                valid[i] = ($urandom_range(0, 3) != 0); done[i] = ($urandom_range(0, 3) != 0);
                exc[i] = ($urandom_range(0, 7) == 0); is_ds[i] = $urandom_range(0, 1);
                is_br[i] = ($urandom_range(0, 2) == 0); br_taken[i] = $urandom_range(0, 1);
                pred_taken[i] = $urandom_range(0, 1); is_store[i] = $urandom_range(0, 1);
                dst_we[i] = $urandom_range(0, 1);
                exc_code[i*5 +: 5] = ($urandom_range(0, 3) == 0) ? 5'h1F : 5'($urandom);
                pc[i*32 +: 32] = {$urandom} & 32'hFFFF_FFFC;
                br_target[i*32 +: 32] = 32'h4000 + 32'($urandom_range(0, 3) * 16);
                pred_target[i*32 +: 32] = ($urandom_range(0, 3) == 0) ? 32'h9000
                                                                      : br_target[i*32 +: 32];
                badvaddr[i*32 +: 32] = $urandom;
                larf[i*5 +: 5] = 5'($urandom);
                pprf[i*PRF_W +: PRF_W] = 6'($urandom); stale[i*PRF_W +: PRF_W] = 6'($urandom);
            end
            ext_int = ($urandom_range(0, 3) == 0) ? 6'($urandom) : 6'd0;
            counter_int = ($urandom_range(0, 15) == 0);
            ip_sw = ($urandom_range(0, 15) == 0) ? 2'($urandom) : 2'd0;
            ie = ($urandom_range(0, 3) == 0); exl = ($urandom_range(0, 3) == 0);
            im = 8'($urandom); epc = $urandom;
            #1;
            model_eval();
            checks++; if (o_cnt !== 2'(e_cnt) || o_st !== 2'(e_st)) begin
                errors++; $display("FAIL rnd_cnt c=%0d got %0d/%0d want %0d/%0d", c, o_cnt, o_st, e_cnt, e_st); end
            cycle();
            checks++; if (o_rn_valid !== e_mask || o_rn_we !== (e_mask & e_we)) begin
                errors++; $display("FAIL rnd_rn c=%0d got %b/%b want %b/%b", c, o_rn_valid, o_rn_we, e_mask, e_mask & e_we); end
            for (int i = 0; i < W; i++) begin
                if (e_mask[i]) begin
                    checks++;
                    if (o_rn_larf[i*5 +: 5] !== e_larf[i*5 +: 5] ||
                        o_rn_pprf[i*PRF_W +: PRF_W] !== e_pprf[i*PRF_W +: PRF_W] ||
                        o_rn_stale[i*PRF_W +: PRF_W] !== e_stale[i*PRF_W +: PRF_W]) begin
                        errors++; $display("FAIL rnd_rn_data c=%0d slot %0d got %h want %h", c, i, o_rn_larf, e_larf); end
                end
            end
            checks++; if (o_flush !== e_flush || o_rvalid !== e_flush || o_rpc !== e_rpc) begin
                errors++; $display("FAIL rnd_redir c=%0d got %b%b %h want %b %h", c, o_flush, o_rvalid, o_rpc, e_flush, e_rpc); end
            checks++; if (o_exc_valid !== e_exc_valid) begin
                errors++; $display("FAIL rnd_exc_valid c=%0d got %b want %b", c, o_exc_valid, e_exc_valid); end
            if (e_exc_valid) begin
                checks++;
                if (o_exc_code !== e_code || o_exc_pc !== e_exc_pc || o_exc_is_ds !== e_exc_ds ||
                    o_exc_bad !== e_exc_bad) begin
                    errors++; $display("FAIL rnd_exc_rec c=%0d got %h %h %b %h want %h %h %b %h", c,
                        o_exc_code, o_exc_pc, o_exc_is_ds, o_exc_bad, e_code, e_exc_pc, e_exc_ds, e_exc_bad); end
            end
            checks++; if (o_bpd_valid !== e_bpd_valid) begin
                errors++; $display("FAIL rnd_bpd_valid c=%0d got %b want %b", c, o_bpd_valid, e_bpd_valid); end
            if (e_bpd_valid) begin
                checks++;
                if (o_bpd_taken !== e_bpd_taken || o_bpd_pc !== e_bpd_pc || o_bpd_tgt !== e_bpd_tgt) begin
                    errors++; $display("FAIL rnd_bpd_rec c=%0d got %b %h %h want %b %h %h", c,
                        o_bpd_taken, o_bpd_pc, o_bpd_tgt, e_bpd_taken, e_bpd_pc, e_bpd_tgt); end
            end
            m_wait = m_wait_n; m_flush = m_flush_n; m_hold = m_hold_n; m_sync = m_sync_n;
        end
        do_reset();
    endtask

    task automatic test_reset_mid_wait();
        set_alu(0, 32'h700); is_br[0] = 1'b1; br_taken[0] = 1'b1; br_target[31:0] = 32'h780;
        #1;
        checks++; if (o_cnt !== 2'd1) begin errors++; $display("FAIL rmw_cnt got %0d want 1", o_cnt); end
        cycle(); clr_slots();
        checks++; if (o_rn_valid !== 2'b01 || o_bpd_valid !== 1'b1) begin
            errors++; $display("FAIL rmw_pre got %b %b want 01 1", o_rn_valid, o_bpd_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (o_rn_valid !== 2'b00 || o_rn_we !== 2'b00 || o_bpd_valid !== 1'b0 ||
                      o_bpd_pc !== 32'd0 || o_flush !== 1'b0 || o_exc_valid !== 1'b0) begin
            errors++; $display("FAIL rmw_async got %b %b %b %h want all zero", o_rn_valid, o_rn_we, o_bpd_valid, o_bpd_pc); end
        rst_n = 1'b1;
        set_alu(0, 32'h900); set_alu(1, 32'h904);
        #1;
        checks++; if (o_cnt !== 2'd2) begin errors++; $display("FAIL rmw_run_cnt got %0d want 2", o_cnt); end
        cycle(); clr_slots();
        checks++; if (o_rvalid !== 1'b0 || o_rn_valid !== 2'b11) begin
            errors++; $display("FAIL rmw_after got %b %b want 0 11", o_rvalid, o_rn_valid); end
    endtask

    initial begin
        test_reset();
        test_alu_pair();
        test_mispredict();
        test_wait_ds();
        test_exception();
        test_interrupt_eret();
        test_stores_exc();
        test_random();
        test_reset_mid_wait();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1);
    end
endmodule
